multiplex_scan_n_1: RTL and testbench
=====================================

// Module: multiplex_scan_n_1
// PURPOSE
//  - Parametrised N:1 multiplexer with a registered output. Successor of the fixed 8:1 combinational mux.
//  - Two modes: MANUAL (the caller chooses the channel) and SCAN (an internal counter steps round-robin through channels).
//  - SCAN mode has a programmable dwell time per channel.
//  - Feeds display/serialiser paths that need one stable, timed channel at a time.
// PARAMETERS
//  N      8  number of input channels, 2..256; need not be a power of 2
//  WIDTH  1  bits per channel
//  DW_W   8  width of the dwell counter and of the dwell input
//  SEL_W  derived as clog2(N), minimum 1; local, not overridable
// PORTS
//  clk      in   1          rising-edge clock
//  rst      in   1          synchronous reset, active-high
//  en       in   1          1 = operate; 0 = freeze all state
//  mode     in   1          0 = MANUAL, 1 = SCAN
//  sel      in   SEL_W      channel select, used in MANUAL mode only
//  dwell    in   DW_W       in SCAN mode, each channel is held for dwell+1 cycles
//  d        in   N*WIDTH    channel k occupies d[k*WIDTH +: WIDTH]
//  y        out  WIDTH      registered data of the selected channel
//  ch       out  SEL_W      channel index currently presented on y
//  y_valid  out  1          y/ch were updated on this clock edge
//  sel_err  out  1          registered flag: MANUAL sel >= N
//  wrap     out  1          one-cycle pulse when SCAN steps from N-1 back to 0
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge): y=0, ch=0, y_valid=0, sel_err=0, wrap=0, dwell_cnt=0.
//    Reset wins over every other input, including a reset in the middle of a dwell.
//  - en=0: y, ch and dwell_cnt hold their values; y_valid=0 and wrap=0.
//  - Latency is 1 cycle: the d/sel sampled at edge t appear on y after edge t.
//    d is resampled every enabled cycle, so y follows changes in d even when ch is unchanged.
//  - MANUAL mode, en=1:
//    - sel < N: ch <= sel, y <= d[sel], sel_err <= 0.
//    - sel >= N: ch and y hold, sel_err <= 1.
//    - y_valid = 1 every enabled cycle; dwell_cnt <= 0.
//  - SCAN mode, en=1:
//    - y <= d[ch_next]; y_valid = 1; sel_err <= 0.
//    - If dwell_cnt == dwell: dwell_cnt <= 0 and ch advances; otherwise dwell_cnt++ and ch holds.
//    - ch advances as ch+1, except N-1 -> 0; on that edge wrap=1. Never produce an index >= N.
//    - dwell = 0: ch advances on every enabled cycle.
//    - dwell is sampled live; if it is lowered below dwell_cnt, advance on the next enabled edge (treat as >=).
//  - Mode switch MANUAL->SCAN: scanning starts from the current ch; dwell_cnt starts at 0.
//  - Mode switch SCAN->MANUAL: sel takes effect on that same edge.
//  - State is {dwell_cnt, ch} only. There is no separate FSM; mode acts as a 2-state selector.
// STRUCTURE
//  - Shared header mux_defs.vh holds:
//    - `MUX_MODE_MANUAL 1'b0 and `MUX_MODE_SCAN 1'b1
//    - clog2 constant function used to derive SEL_W
//  - Sub-module mux_n_1 #(N,WIDTH): purely combinational selection of d[idx].
//    It returns 0 when idx >= N. The top level owns all registers and the counters.
// TESTING (N=8, WIDTH=1 unless stated)
//  1. Reset: assert rst for 2 cycles with d=8'hFF, mode=1.
//     -> y=0, ch=0, y_valid=0, wrap=0 on every edge while rst=1.
//  2. MANUAL sweep: d=8'b1011_0010, sel=0..7, one value per cycle.
//     -> one cycle later y = 0,1,0,0,1,1,0,1; ch = sel; y_valid=1.
//  3. SCAN with dwell=2, d=8'hA5.
//     -> each ch held exactly 3 cycles, sequence 0..7,0.
//     -> wrap high for 1 cycle only on the 7->0 edge, i.e. 24 cycles after scan start.
//  4. N=5, WIDTH=4, SCAN dwell=0.
//     -> ch = 0,1,2,3,4,0; wrap on the 4->0 edge.
//     -> MANUAL sel=6 -> sel_err=1, y and ch unchanged.
//  5. en=0 for 4 cycles in mid-dwell (dwell_cnt=1).
//     -> y and ch frozen, y_valid=0; after en=1 the remaining dwell completes without restarting.
//  6. Rotate a single 1 through d while MANUAL sel=6 (8 rotations).
//     -> y=1 only in the cycle after d[6]=1.
//     -> rst asserted mid-SCAN -> ch=0 on the next edge.

Source files
------------

// File: rtl/multiplex_scan_n_1_pkg.sv
// Shared constants for the scanning N:1 multiplexer: mode encodings and
// the select-width helper.
package multiplex_scan_n_1_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // ceil(log2(n)), never below 1 so a 2-channel mux still has a select bit
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < n) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/multiplex_scan_n_1_mux.sv
// Purely combinational N:1 channel selector; out-of-range index yields 0.
module mux_n_1
  import multiplex_scan_n_1_pkg::*;
#(
  parameter  int N     = 8,
  parameter  int WIDTH = 1,
  localparam int SEL_W = clog2_min1(N)
) (
  input  logic [N*WIDTH-1:0] d,
  input  logic [SEL_W-1:0]   idx,
  output logic [WIDTH-1:0]   y
);

  always_comb begin
    y = '0;
    for (int k = 0; k < N; k++)
      if (idx == SEL_W'(k)) y = d[k*WIDTH +: WIDTH];
  end

endmodule

// File: rtl/multiplex_scan_n_1.sv
// Registered N:1 mux with manual channel select or round-robin scan with
// a programmable per-channel dwell.
module multiplex_scan_n_1
  import multiplex_scan_n_1_pkg::*;
#(
  parameter  int N     = 8,
  parameter  int WIDTH = 1,
  parameter  int DW_W  = 8,
  localparam int SEL_W = clog2_min1(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [DW_W-1:0]    dwell,
  input  logic [N*WIDTH-1:0] d,
  output logic [WIDTH-1:0]   y,
  output logic [SEL_W-1:0]   ch,
  output logic               y_valid,
  output logic               sel_err,
  output logic               wrap
);

  // one extra bit so N itself is representable when N is a power of two
  localparam logic [SEL_W:0] N_EXT = (SEL_W+1)'(N);

  logic [DW_W-1:0]  dwell_cnt;
  logic [SEL_W-1:0] ch_next;
  logic [WIDTH-1:0] y_sel;
  logic             sel_ok, last, adv;

  assign sel_ok = {1'b0, sel} < N_EXT;
  assign last   = (ch == SEL_W'(N-1));
  // >= rather than == so a live-lowered dwell still releases the channel
  assign adv    = (dwell_cnt >= dwell);

  always_comb begin
    ch_next = ch;
    if (mode == MODE_MANUAL) begin
      if (sel_ok) ch_next = sel;
    end else if (adv) begin
      ch_next = last ? '0 : ch + 1'b1;
    end
  end

  mux_n_1 #(.N(N), .WIDTH(WIDTH)) u_mux (
    .d   (d),
    .idx (ch_next),
    .y   (y_sel)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      y         <= '0;
      ch        <= '0;
      y_valid   <= 1'b0;
      sel_err   <= 1'b0;
      wrap      <= 1'b0;
      dwell_cnt <= '0;
    end else if (!en) begin
      y_valid <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      y_valid <= 1'b1;
      ch      <= ch_next;
      if (mode == MODE_MANUAL) begin
        wrap      <= 1'b0;
        dwell_cnt <= '0;
        sel_err   <= !sel_ok;
        if (sel_ok) y <= y_sel;
      end else begin
        sel_err   <= 1'b0;
        wrap      <= adv && last;
        dwell_cnt <= adv ? '0 : dwell_cnt + 1'b1;
        y         <= y_sel;
      end
    end
  end

endmodule

// File: tb/tb_multiplex_scan_n_1.sv
// Bench for multiplex_scan_n_1: an 8x1 and a 5x4 instance share controls,
// each checked every cycle against a behavioural model plus literal checks.
module tb_multiplex_scan_n_1;

  logic        clk, rst, en, mode;
  logic [2:0]  sel;
  logic [7:0]  dwell;
  logic [7:0]  d8;
  logic [19:0] d5;
  logic        y8, yv8, err8, wrap8;
  logic [2:0]  ch8, ch5;
  logic [3:0]  y5;
  logic        yv5, err5, wrap5;

  int n_chk  = 0;
  int n_fail = 0;
  bit started = 0;

  multiplex_scan_n_1 #(.N(8), .WIDTH(1), .DW_W(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .dwell(dwell),
    .d(d8), .y(y8), .ch(ch8), .y_valid(yv8), .sel_err(err8), .wrap(wrap8)
  );

  multiplex_scan_n_1 #(.N(5), .WIDTH(4), .DW_W(8)) dut5 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .dwell(dwell),
    .d(d5), .y(y5), .ch(ch5), .y_valid(yv5), .sel_err(err5), .wrap(wrap5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int y; int ch; int cnt; bit yv; bit err; bit wrap;
  } mstate_t;

  mstate_t m8, m5;

  // Behavioural model: channel index, dwell count and output value as plain integers.
  function automatic mstate_t mstep(input mstate_t s, input int n, input int w,
                                    input bit r, input bit e, input bit md,
                                    input int sl, input int dw, input longint dd);
    mstate_t o;
    longint mask;
    o = s;
    mask = (64'sd1 <<< w) - 1;
    if (r) begin
      o.y = 0; o.ch = 0; o.cnt = 0; o.yv = 0; o.err = 0; o.wrap = 0;
    end else if (!e) begin
      o.yv = 0; o.wrap = 0;
    end else if (!md) begin
      o.yv = 1; o.wrap = 0; o.cnt = 0;
      if (sl < n) begin
        o.ch = sl; o.err = 0;
        o.y = int'((dd >> (sl*w)) & mask);
      end else begin
        o.err = 1;
      end
    end else begin
      o.yv = 1; o.err = 0;
      if (s.cnt >= dw) begin
        o.cnt = 0;
        o.wrap = (s.ch == n-1);
        o.ch = (s.ch + 1) % n;
      end else begin
        o.cnt = s.cnt + 1;
        o.wrap = 0;
      end
      o.y = int'((dd >> (o.ch*w)) & mask);
    end
    return o;
  endfunction

  always @(posedge clk) begin
    m8 <= mstep(m8, 8, 1, rst, en, mode, int'(sel), int'(dwell), longint'(d8));
    m5 <= mstep(m5, 5, 4, rst, en, mode, int'(sel), int'(dwell), longint'(d5));
    started <= started | rst;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("m8.y", 32'(y8), 32'(m8.y));
      chk("m8.ch", 32'(ch8), 32'(m8.ch));
      chk("m8.y_valid", 32'(yv8), 32'(m8.yv));
      chk("m8.sel_err", 32'(err8), 32'(m8.err));
      chk("m8.wrap", 32'(wrap8), 32'(m8.wrap));
      chk("m5.y", 32'(y5), 32'(m5.y));
      chk("m5.ch", 32'(ch5), 32'(m5.ch));
      chk("m5.y_valid", 32'(yv5), 32'(m5.yv));
      chk("m5.sel_err", 32'(err5), 32'(m5.err));
      chk("m5.wrap", 32'(wrap5), 32'(m5.wrap));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] sweep_exp;
  logic [7:0] one_hot;

  initial begin
    rst = 1; en = 1; mode = 1; sel = 0; dwell = 0; d8 = 8'hFF; d5 = '0;
    sweep_exp = 8'b1011_0010;

    // reset held two cycles with data and scan mode active
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst.y", 32'(y8), 0);
      chk("rst.ch", 32'(ch8), 0);
      chk("rst.y_valid", 32'(yv8), 0);
      chk("rst.wrap", 32'(wrap8), 0);
    end
    rst = 0;

    // manual sweep
    mode = 0; d8 = 8'b1011_0010;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      tick();
      chk("sweep.y", 32'(y8), 32'(sweep_exp[s]));
      chk("sweep.ch", 32'(ch8), 32'(s));
      chk("sweep.y_valid", 32'(yv8), 1);
    end

    // scan, dwell=2, starting from channel 0
    sel = 0; tick();
    mode = 1; dwell = 2; d8 = 8'hA5;
    for (int t = 1; t <= 26; t++) begin
      tick();
      chk("scan3.ch", 32'(ch8), 32'((t/3) % 8));
      chk("scan3.wrap", 32'(wrap8), (t == 24) ? 1 : 0);
    end

    // freeze mid-dwell on channel 1 with dwell_cnt=1
    tick(); chk("frz.pre_ch", 32'(ch8), 1);
    tick();
    en = 0; d8 = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("frz.ch", 32'(ch8), 1);
      chk("frz.y", 32'(y8), 0);
      chk("frz.y_valid", 32'(yv8), 0);
    end
    en = 1;
    tick(); chk("frz.resume_ch", 32'(ch8), 1);
    chk("frz.resume_y", 32'(y8), 1);
    tick(); chk("frz.adv_ch", 32'(ch8), 2);

    // N=5, WIDTH=4 scan with dwell=0, then out-of-range manual select
    mode = 0; sel = 0; tick();
    mode = 1; dwell = 0; d5 = {4'h9, 4'h7, 4'h5, 4'h3, 4'h1};
    for (int t = 1; t <= 5; t++) begin
      tick();
      chk("n5.ch", 32'(ch5), 32'(t % 5));
      chk("n5.y", 32'(y5), 32'(2*(t % 5) + 1));
      chk("n5.wrap", 32'(wrap5), (t == 5) ? 1 : 0);
    end
    mode = 0; sel = 6;
    tick();
    chk("n5.sel_err", 32'(err5), 1);
    chk("n5.hold_ch", 32'(ch5), 0);
    chk("n5.hold_y", 32'(y5), 1);
    chk("n8.sel6_err", 32'(err8), 0);
    chk("n8.sel6_ch", 32'(ch8), 6);

    // rotate a single one through d while selecting channel 6
    for (int i = 0; i < 8; i++) begin
      one_hot = 8'h01 << i;
      d8 = one_hot;
      tick();
      chk("rot.y", 32'(y8), (i == 6) ? 1 : 0);
    end

    // reset in the middle of a scan dwell
    mode = 1; dwell = 1;
    for (int i = 0; i < 5; i++) tick();
    rst = 1;
    tick();
    chk("rstmid.ch8", 32'(ch8), 0);
    chk("rstmid.ch5", 32'(ch5), 0);
    chk("rstmid.y8", 32'(y8), 0);
    chk("rstmid.y_valid", 32'(yv8), 0);
    rst = 0;
    tick();
    chk("rstmid.resume_valid", 32'(yv8), 1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
